// File: rtl/complex_pkg.sv
// Shared types and helpers for the complex divider and its companion blocks.
package complex_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic int qw(input int width, input int frac);
    return width + frac + 1;
  endfunction

endpackage

// File: rtl/serial_udiv.sv
// Unsigned restoring divider datapath: one quotient bit per step, MSB first.
// The dividend's high NW-QN bits seed the remainder, so they must already be below the divisor.
module serial_udiv #(
  parameter int NW  = 40,
  parameter int DVW = 32,
  parameter int QN  = 24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [NW-1:0]   dividend,
  input  logic [DVW-1:0]  divisor,
  output logic [QN-1:0]   quo
);

  logic [DVW-1:0] rem_q, rem_d;
  logic [DVW-1:0] dvs_q, dvs_d;
  logic [QN-1:0]  quo_q, quo_d;
  logic [DVW:0]   trial_s;
  logic [DVW-1:0] diff_s;

  // Next-state of the remainder, divisor and quotient shift register
  always_comb begin
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    trial_s = {rem_q, quo_q[QN-1]};
    diff_s  = trial_s[DVW-1:0] - dvs_q;
    if (load) begin
      rem_d = DVW'(dividend[NW-1:QN]);
      quo_d = dividend[QN-1:0];
      dvs_d = divisor;
    end else if (step) begin
      // Remainder stays below the divisor, so the difference always fits DVW bits
      if (trial_s >= {1'b0, dvs_q}) begin
        rem_d = diff_s;
        quo_d = {quo_q[QN-2:0], 1'b1};
      end else begin
        rem_d = trial_s[DVW-1:0];
        quo_d = {quo_q[QN-2:0], 1'b0};
      end
    end else begin
      rem_d = rem_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      dvs_q <= '0;
      quo_q <= '0;
    end else begin
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      quo_q <= quo_d;
    end
  end

  assign quo = quo_q;

endmodule

// File: rtl/complex_div.sv
// Sequential fixed-point complex divider q = a / b with valid/ready input and a one-cycle result strobe.
// The real and imaginary quotients run on two serial dividers stepped by one shared FSM.
module complex_div
  import complex_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              ab_valid,
  output logic                              ab_ready,
  input  logic signed [WIDTH-1:0]           ar,
  input  logic signed [WIDTH-1:0]           ai,
  input  logic signed [WIDTH-1:0]           br,
  input  logic signed [WIDTH-1:0]           bi,
  output logic                              q_valid,
  output logic signed [qw(WIDTH,FRAC)-1:0]  qr,
  output logic signed [qw(WIDTH,FRAC)-1:0]  qi,
  output logic                              dz
);

  localparam int QW = qw(WIDTH, FRAC);
  localparam int K  = WIDTH + FRAC;
  localparam int MW = 2 * WIDTH;
  localparam int PW = MW + 1;
  localparam int NW = MW + FRAC;
  localparam int CW = $clog2(K + 1);

  state_e                  state_q, state_d;
  logic signed [WIDTH-1:0] ar_q, ar_d, ai_q, ai_d, br_q, br_d, bi_q, bi_d;
  logic                    neg_r_q, neg_r_d, neg_i_q, neg_i_d;
  logic                    dz_pend_q, dz_pend_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    ab_ready_q, ab_ready_d;
  logic                    q_valid_q, q_valid_d;
  logic signed [QW-1:0]    qr_q, qr_d, qi_q, qi_d;
  logic                    dz_q, dz_d;

  logic signed [PW-1:0]    ar_x_s, ai_x_s, br_x_s, bi_x_s, num_r_s, num_i_s;
  logic [MW-1:0]           mag_r_s, mag_i_s, den_s;
  logic                    load_s, step_s;
  logic [K-1:0]            quo_r_s, quo_i_s;

  function automatic logic signed [QW-1:0] apply_sign(input logic neg, input logic [K-1:0] mag);
    logic signed [QW-1:0] m;
    m = {1'b0, mag};
    return neg ? -m : m;
  endfunction

  // Numerators, magnitudes and denominator from the captured operands
  always_comb begin
    ar_x_s  = PW'(ar_q);
    ai_x_s  = PW'(ai_q);
    br_x_s  = PW'(br_q);
    bi_x_s  = PW'(bi_q);
    num_r_s = ar_x_s * br_x_s + ai_x_s * bi_x_s;
    num_i_s = ai_x_s * br_x_s - ar_x_s * bi_x_s;
    // |num| never exceeds 2^(2*WIDTH-1), so the low MW bits of the negation are exact
    mag_r_s = num_r_s[PW-1] ? (~num_r_s[MW-1:0] + MW'(1)) : num_r_s[MW-1:0];
    mag_i_s = num_i_s[PW-1] ? (~num_i_s[MW-1:0] + MW'(1)) : num_i_s[MW-1:0];
    den_s   = MW'(br_x_s * br_x_s) + MW'(bi_x_s * bi_x_s);
    load_s  = (state_q == PREP) && (den_s != '0);
    step_s  = (state_q == DIV);
  end

  // FSM next-state and output register values
  always_comb begin
    state_d    = state_q;
    ar_d       = ar_q;
    ai_d       = ai_q;
    br_d       = br_q;
    bi_d       = bi_q;
    neg_r_d    = neg_r_q;
    neg_i_d    = neg_i_q;
    dz_pend_d  = dz_pend_q;
    cnt_d      = cnt_q;
    ab_ready_d = ab_ready_q;
    q_valid_d  = 1'b0;
    qr_d       = qr_q;
    qi_d       = qi_q;
    dz_d       = dz_q;
    case (state_q)
      IDLE: begin
        if (ab_valid && ab_ready_q) begin
          ar_d       = ar;
          ai_d       = ai;
          br_d       = br;
          bi_d       = bi;
          ab_ready_d = 1'b0;
          state_d    = PREP;
        end else begin
          state_d = IDLE;
        end
      end
      PREP: begin
        neg_r_d = num_r_s[PW-1];
        neg_i_d = num_i_s[PW-1];
        if (den_s == '0) begin
          dz_pend_d = 1'b1;
          state_d   = DONE;
        end else begin
          dz_pend_d = 1'b0;
          cnt_d     = CW'(K);
          state_d   = DIV;
        end
      end
      DIV: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end else begin
          state_d = DIV;
        end
      end
      DONE: begin
        if (dz_pend_q) begin
          qr_d = '0;
          qi_d = '0;
        end else begin
          qr_d = apply_sign(neg_r_q, quo_r_s);
          qi_d = apply_sign(neg_i_q, quo_i_s);
        end
        dz_d       = dz_pend_q;
        q_valid_d  = 1'b1;
        ab_ready_d = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        ab_ready_d = 1'b1;
        state_d    = IDLE;
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ar_q       <= '0;
      ai_q       <= '0;
      br_q       <= '0;
      bi_q       <= '0;
      neg_r_q    <= 1'b0;
      neg_i_q    <= 1'b0;
      dz_pend_q  <= 1'b0;
      cnt_q      <= '0;
      ab_ready_q <= 1'b1;
      q_valid_q  <= 1'b0;
      qr_q       <= '0;
      qi_q       <= '0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      ar_q       <= ar_d;
      ai_q       <= ai_d;
      br_q       <= br_d;
      bi_q       <= bi_d;
      neg_r_q    <= neg_r_d;
      neg_i_q    <= neg_i_d;
      dz_pend_q  <= dz_pend_d;
      cnt_q      <= cnt_d;
      ab_ready_q <= ab_ready_d;
      q_valid_q  <= q_valid_d;
      qr_q       <= qr_d;
      qi_q       <= qi_d;
      dz_q       <= dz_d;
    end
  end

  serial_udiv #(.NW(NW), .DVW(MW), .QN(K)) u_div_r (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .step     (step_s),
    .dividend ({mag_r_s, {FRAC{1'b0}}}),
    .divisor  (den_s),
    .quo      (quo_r_s)
  );

  serial_udiv #(.NW(NW), .DVW(MW), .QN(K)) u_div_i (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .step     (step_s),
    .dividend ({mag_i_s, {FRAC{1'b0}}}),
    .divisor  (den_s),
    .quo      (quo_i_s)
  );

  assign ab_ready = ab_ready_q;
  assign q_valid  = q_valid_q;
  assign qr       = qr_q;
  assign qi       = qi_q;
  assign dz       = dz_q;

endmodule

// File: tb/tb_complex_div.sv
// Directed bench for complex_div at WIDTH=4, FRAC=4 with hand-computed quotients.
module tb_complex_div;

  logic              clk;
  logic              rst;
  logic              ab_valid;
  logic              ab_ready;
  logic signed [3:0] ar, ai, br, bi;
  logic              q_valid;
  logic signed [8:0] qr, qi;
  logic              dz;

  int errors = 0;
  int checks = 0;

  complex_div #(.WIDTH(4), .FRAC(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .ab_valid (ab_valid),
    .ab_ready (ab_ready),
    .ar       (ar),
    .ai       (ai),
    .br       (br),
    .bi       (bi),
    .q_valid  (q_valid),
    .qr       (qr),
    .qi       (qi),
    .dz       (dz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!ab_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) check({tag, ".ready_timeout"}, ab_ready, 1);
  endtask

  task automatic set_ops(input int xar, input int xai, input int xbr, input int xbi);
    ar = xar[3:0];
    ai = xai[3:0];
    br = xbr[3:0];
    bi = xbi[3:0];
  endtask

  task automatic run_op(input string tag, input int xar, input int xai, input int xbr, input int xbi,
                        input int eqr, input int eqi, input int edz, input int elat);
    int lat;
    wait_ready(tag);
    set_ops(xar, xai, xbr, xbi);
    ab_valid = 1'b1;
    @(posedge clk); #1;
    ab_valid = 1'b0;
    check({tag, ".busy"}, ab_ready, 0);
    lat = 0;
    while (!q_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".latency"}, lat, elat);
    check({tag, ".qr"}, qr, eqr);
    check({tag, ".qi"}, qi, eqi);
    check({tag, ".dz"}, dz, edz);
    @(posedge clk); #1;
    check({tag, ".pulse"}, q_valid, 0);
  endtask

  int t_ar [4] = '{4, 1, -8, 2};
  int t_ai [4] = '{2, 0, -8, 0};
  int t_br [4] = '{1, 0,  1, 2};
  int t_bi [4] = '{1, 3, -1, 0};
  int t_qr [4] = '{48, 0,    0, 16};
  int t_qi [4] = '{-16, -5, -128, 0};

  initial begin
    int exp_q[$];
    int acc, got, e, pulses;
    rst = 1'b1;
    ab_valid = 1'b0;
    set_ops(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset.ab_ready", ab_ready, 1);
    check("reset.q_valid", q_valid, 0);
    check("reset.qr", qr, 0);
    check("reset.qi", qi, 0);
    check("reset.dz", dz, 0);

    run_op("exact", 4, 2, 1, 1, 48, -16, 0, 10);
    run_op("trunc", 1, 0, 0, 3, 0, -5, 0, 10);
    run_op("ext1", -8, -8, 1, 0, -128, -128, 0, 10);
    run_op("ext2", -8, -8, 1, -1, 0, -128, 0, 10);
    run_op("divzero", 3, -2, 0, 0, 0, 0, 1, 2);
    run_op("after_dz", 1, 0, 0, 3, 0, -5, 0, 10);

    // Handshake: ab_valid held high with operands changing every cycle
    wait_ready("hs");
    acc = 0;
    got = 0;
    ab_valid = 1'b1;
    for (int s = 0; s < 60; s++) begin
      set_ops(t_ar[s % 4], t_ai[s % 4], t_br[s % 4], t_bi[s % 4]);
      if (q_valid) begin
        got++;
        if (exp_q.size() == 0) begin
          check("hs.extra_pulse", got, acc);
        end else begin
          e = exp_q.pop_front();
          check("hs.qr", qr, t_qr[e]);
          check("hs.qi", qi, t_qi[e]);
          check("hs.dz", dz, 0);
        end
      end
      if (ab_ready) begin
        exp_q.push_back(s % 4);
        acc++;
      end
      @(posedge clk); #1;
    end
    ab_valid = 1'b0;
    for (int s = 0; s < 20; s++) begin
      if (q_valid) begin
        got++;
        if (exp_q.size() == 0) begin
          check("hs.extra_pulse", got, acc);
        end else begin
          e = exp_q.pop_front();
          check("hs.qr", qr, t_qr[e]);
          check("hs.qi", qi, t_qi[e]);
          check("hs.dz", dz, 0);
        end
      end
      @(posedge clk); #1;
    end
    check("hs.accepts", acc, 6);
    check("hs.pulses", got, acc);

    // Reset four cycles into an operation
    run_op("pre_rst", 4, 2, 1, 1, 48, -16, 0, 10);
    wait_ready("rst");
    set_ops(4, 2, 1, 1);
    ab_valid = 1'b1;
    @(posedge clk); #1;
    ab_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst.ab_ready", ab_ready, 1);
    check("rst.q_valid", q_valid, 0);
    check("rst.qr", qr, 0);
    check("rst.qi", qi, 0);
    check("rst.dz", dz, 0);
    pulses = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (q_valid) pulses++;
    end
    check("rst.no_pulse", pulses, 0);
    run_op("post_rst", 2, 0, 2, 0, 16, 0, 0, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/complex_div.md
# complex_div

Sequential fixed-point complex divider: computes q = a / b for signed complex operands using a valid/ready input handshake and a one-cycle output strobe. It is the inverse-direction companion to the team's pipelined complex multiplier. It is used to undo channel or gain products, for example equalisation by division. It sits downstream of the multiplier and shares the same WIDTH-bit signed operand format.

## Interface
- WIDTH, 16: bit width of each signed input component.
- FRAC, 8: number of fractional bits in each quotient component.
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- ab_valid  input  1  operands present.
- ab_ready  output  1  divider idle; operands are accepted when ab_valid && ab_ready at a rising edge.
- ar, ai  input  WIDTH  dividend real and imaginary parts, signed.
- br, bi  input  WIDTH  divisor real and imaginary parts, signed.
- q_valid  output  1  one-cycle strobe; result valid.
- qr, qi  output  QW = WIDTH+FRAC+1  quotient, signed, with FRAC fractional bits.
- dz  output  1  divide-by-zero flag, qualified by q_valid.

## Operation
- Arithmetic:
  - num_r = ar·br + ai·bi
  - num_i = ai·br − ar·bi
  - den = br² + bi², unsigned, 2·WIDTH bits.
  - |num| fits in 2·WIDTH bits.
- Each component is computed as magnitude quotient (|num|·2^FRAC) / den, truncated toward zero, then negated if num < 0.
  - Magnitude is at most 2^(WIDTH−1)·2^FRAC, so no saturation is required.
- FSM with states IDLE, PREP, DIV, DONE:
  - **IDLE:** ab_ready=1. On accept, capture operands and go to PREP.
  - **PREP:** register num_r, num_i, den, and the numerator signs.
    - If den==0, set qr=qi=0 and dz=1, and go to DONE.
    - Otherwise clear the partial remainders, set the iteration counter to WIDTH+FRAC, and go to DIV.
  - **DIV:** one restoring shift-subtract step per cycle on both components in parallel. When the counter reaches its last step, go to DONE.
  - **DONE:** apply signs, load qr, qi and dz, assert q_valid for exactly this cycle, then go to IDLE.
- qr, qi and dz hold their last value until the next DONE.
- ab_valid is ignored outside IDLE. No queueing is performed; the upstream must hold its operands until ab_ready is high.

## Timing
- Reset values:
  - state=IDLE
  - ab_ready=1
  - q_valid=0
  - qr=qi=0
  - dz=0
  - all internal registers 0
- Latency is counted from the accept edge to the edge that raises q_valid:
  - normal case: WIDTH+FRAC+2 cycles (PREP 1, DIV WIDTH+FRAC, DONE 1);
  - den==0: 2 cycles.
- ab_ready is deasserted from the cycle after accept until the cycle after the q_valid cycle. Throughput is one division per WIDTH+FRAC+3 cycles.
- rst asserted in any state aborts the operation. On the next edge, all registers return to their reset values and no q_valid is produced for the aborted operation.
- Back-to-back operation: an operand set presented with ab_valid held high is accepted on the first edge after DONE.

## Structure
- Shared package complex_pkg:
  - state enum {IDLE, PREP, DIV, DONE};
  - function qw(WIDTH, FRAC) returning WIDTH+FRAC+1.
- One natural sub-module, serial_udiv: an unsigned restoring-divider datapath (load, step, quotient/remainder registers) parameterised by dividend and divisor widths.
  - It is instantiated twice, once for the real path and once for the imaginary path.
  - Both instances are driven by the single FSM/counter in complex_div.

## Test plan
Settings for all cases: WIDTH=4, FRAC=4 (QW=9, latency 10).
- **Exact quotient:** a=(4,2), b=(1,1) → qr=48 (3.0), qi=−16 (−1.0), dz=0. q_valid occurs 10 cycles after accept.
- **Truncation:** a=(1,0), b=(0,3) → qr=0, qi=−5 (−0.3125; exact −5.33 truncated toward zero).
- **Extremes:** a=(−8,−8), b=(1,0) → qr=−128, qi=−128. a=(−8,−8), b=(1,−1) → qr=0, qi=−128.
- **Divide by zero:** a=(3,−2), b=(0,0) → qr=qi=0, dz=1. q_valid occurs 2 cycles after accept.
- **Handshake:** hold ab_valid=1 with changing operands while the divider is busy → only operands present when ab_ready=1 are accepted. Each accept yields exactly one q_valid pulse, with results matching the operands in order.
- **Reset mid-DIV:** assert rst for 1 cycle, 4 cycles after accept → no q_valid for that operation. ab_ready=1, qr=qi=0 and dz=0 on the next cycle. A following a=(2,0), b=(2,0) → qr=16, qi=0.
